b_bus_select_reg: RTL and testbench
===================================

// Module: b_bus_select_reg
// PURPOSE
//  Parametrised, registered successor to the combinational B-bus source selector.
//  Selects one of NUM_SRC source registers (MDR, PC, MBRU, R1..R4, R, ...) onto the B bus.
//  The selected value is captured into an output register behind a valid/ready handshake.
//  Invalid select codes are counted. Sits between the register file/special registers and the ALU B input.
// PARAMETERS
//  DATA_W      24        B-bus width in bits
//  NUM_SRC     8         number of selectable sources; codes 1..NUM_SRC, code 0 = no source
//  SEL_W       4         select-code width; must satisfy 2**SEL_W > NUM_SRC
//  NARROW_W    8         width kept for sources flagged narrow
//  NARROW_MASK 8'h05     bit i=1 -> source code i+1 is narrow (default: MDR, MBRU)
//  ERR_CNT_W   8         width of the invalid-select counter
// PORTS
//  clk         in   1                  system clock, rising edge
//  reset       in   1                  synchronous, active-high reset
//  src_flat    in   NUM_SRC*DATA_W     packed sources; src i (code i+1) = src_flat[i*DATA_W +: DATA_W]
//  b_control   in   SEL_W              source select code
//  req_valid   in   1                  select request present this cycle
//  req_ready   out  1                  block can accept a request
//  B_bus       out  DATA_W             registered bus value
//  bus_valid   out  1                  B_bus holds an unconsumed value
//  bus_ready   in   1                  consumer takes B_bus this cycle
//  sel_err     out  1                  sticky: an invalid code was accepted
//  err_count   out  ERR_CNT_W          number of accepted invalid codes, saturating
// BEHAVIOUR
//  Reset (reset=1 at clk edge): B_bus=0, bus_valid=0, sel_err=0, err_count=0. Reset has priority over all other inputs.
//  req_ready = !bus_valid || bus_ready (combinational; a single output register passes data through when drained same cycle).
//  Accept: req_valid && req_ready at a clk edge. On the next edge, B_bus = selected value and bus_valid=1.
//  Latency: 1 cycle from accept to bus_valid.
//  Consume: bus_valid && bus_ready. Without a simultaneous accept, bus_valid -> 0 and B_bus holds its last value.
//  Simultaneous consume+accept: new value loaded, bus_valid stays 1, no bubble.
//  Stall: bus_valid && !bus_ready. B_bus and bus_valid hold; req_ready=0; source changes are ignored.
//  Selection: code 0 -> all zeros (valid transfer).
//   Code k in 1..NUM_SRC -> source k-1.
//   If NARROW_MASK[k-1] is set: {zeros, src[NARROW_W-1:0]}. Otherwise: the full DATA_W bits.
//  Invalid code (k > NUM_SRC): loads zeros, bus_valid=1 (the transfer still completes), sel_err=1 (sticky until reset).
//   err_count += 1, saturating at all-ones; no wrap.
//  Sources are sampled only at the accept edge; the output never changes combinationally with sources.
//  Reset mid-transfer discards the held value; no partial state survives.
// TESTING
//  1 Reset: hold reset 2 cycles with req_valid=1 -> bus_valid=0, B_bus=0, err_count=0, req_ready=1 after release.
//  2 Narrow/wide select: src code1 (MDR)=24'hABCD12, req code1 -> next cycle B_bus=24'h000012.
//    Code4 (R1)=24'h123456 -> B_bus=24'h123456.
//  3 Back-pressure: bus_ready=0, accept code4 then present code5 for 3 cycles -> B_bus stays R1, req_ready=0.
//    Raise bus_ready -> code5 loaded the next edge.
//  4 Streaming: bus_ready=1, req_valid=1, codes 4,5,6,7,8 on consecutive cycles -> R1..R outputs on 5 consecutive cycles, no bubble.
//  5 Invalid code: code 9 with NUM_SRC=8 -> B_bus=0, bus_valid=1, sel_err=1, err_count=1.
//    300 invalid accepts -> err_count=8'hFF, held.
//  6 Reset mid-stall: bus_valid=1, bus_ready=0, assert reset -> bus_valid=0, sel_err=0 the next edge.

Source files
------------

// File: rtl/b_bus_select_reg.sv
// Registered B-bus source selector: picks one of NUM_SRC sources (or zero) and
// holds it in a single output register behind a valid/ready handshake.
module b_bus_select_reg #(
  parameter int                 DATA_W      = 24,
  parameter int                 NUM_SRC     = 8,
  parameter int                 SEL_W       = 4,
  parameter int                 NARROW_W    = 8,
  parameter logic [NUM_SRC-1:0] NARROW_MASK = 'h05,
  parameter int                 ERR_CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_flat,
  input  logic [SEL_W-1:0]          b_control,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic [DATA_W-1:0]         B_bus,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic                      sel_err,
  output logic [ERR_CNT_W-1:0]      err_count
);

  // Bits above NARROW_W are cleared for narrow sources; a shift of DATA_W
  // yields an all-zero clear mask, so NARROW_W == DATA_W keeps everything.
  localparam logic [DATA_W-1:0] NARROW_KEEP = ~({DATA_W{1'b1}} << NARROW_W);

  function automatic logic [DATA_W-1:0] select_src(
    input logic [NUM_SRC*DATA_W-1:0] srcs,
    input logic [SEL_W-1:0]          code
  );
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(code) == i + 1) begin
        v = srcs[i*DATA_W +: DATA_W];
        if (NARROW_MASK[i]) v = v & NARROW_KEEP;
      end
    end
    return v;
  endfunction

  function automatic logic code_invalid(input logic [SEL_W-1:0] code);
    return int'(code) > NUM_SRC;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + ERR_CNT_W'(1);
  endfunction

  logic                 accept_p0;
  logic [DATA_W-1:0]    sel_data_p0;
  logic                 sel_bad_p0;

  logic [DATA_W-1:0]    data_p1;
  logic                 vld_p1;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_cnt;

  // ---- stage p0: request decode; sources are only used on the accept edge
  assign req_ready   = !vld_p1 || bus_ready;
  assign accept_p0   = req_valid && req_ready;
  assign sel_data_p0 = select_src(src_flat, b_control);
  assign sel_bad_p0  = code_invalid(b_control);

  // ---- stage p1: output register and error bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1    <= '0;
      vld_p1     <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (accept_p0) begin
        data_p1 <= sel_data_p0;
        vld_p1  <= 1'b1;
        if (sel_bad_p0) begin
          err_sticky <= 1'b1;
          err_cnt    <= sat_inc(err_cnt);
        end
      end else if (vld_p1 && bus_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign B_bus     = data_p1;
  assign bus_valid = vld_p1;
  assign sel_err   = err_sticky;
  assign err_count = err_cnt;

endmodule

// File: tb/tb_b_bus_select_reg.sv
// Bench for b_bus_select_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_b_bus_select_reg;

  localparam int DW = 24;
  localparam int NS = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*DW-1:0]  src_flat;
  logic [3:0]        b_control;
  logic              req_valid;
  logic              req_ready;
  logic [DW-1:0]     B_bus;
  logic              bus_valid;
  logic              bus_ready;
  logic              sel_err;
  logic [7:0]        err_count;

  logic [DW-1:0]     src [NS];

  int checks = 0;
  int errors = 0;

  b_bus_select_reg dut (
    .clk       (clk),
    .reset     (reset),
    .src_flat  (src_flat),
    .b_control (b_control),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .B_bus     (B_bus),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_flat = '0;
    for (int i = 0; i < NS; i++) src_flat[i*DW +: DW] = src[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one output slot, sources MDR (code1) and MBRU (code3)
  // are narrow 8-bit, codes above 8 are errors that still deliver zero.
  bit            started = 0;
  bit            m_valid = 0;
  logic [DW-1:0] m_bus   = '0;
  bit            m_err   = 0;
  int            m_cnt   = 0;

  function automatic logic [DW-1:0] expect_sel(input int code);
    if (code == 0 || code > NS) return '0;
    if (code == 1 || code == 3) return {16'h0, src[code-1][7:0]};
    return src[code-1];
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      m_valid = 0; m_bus = '0; m_err = 0; m_cnt = 0;
    end else if (req_valid && (!m_valid || bus_ready)) begin
      m_valid = 1;
      m_bus   = expect_sel(int'(b_control));
      if (int'(b_control) > NS) begin
        m_err = 1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end else if (bus_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_bus_valid", 32'(bus_valid), 32'(m_valid));
      chk("model_B_bus",     32'(B_bus),     32'(m_bus));
      chk("model_sel_err",   32'(sel_err),   32'(m_err));
      chk("model_err_count", 32'(err_count), 32'(m_cnt));
      chk("model_req_ready", 32'(req_ready), 32'(!m_valid || bus_ready));
    end
  end

  initial begin
    logic [DW-1:0] lit [4:8];
    for (int i = 0; i < NS; i++) src[i] = DW'($urandom);
    reset = 1; req_valid = 1; b_control = 4'd4; bus_ready = 0;

    // Reset held two cycles with a request pending
    repeat (2) @(posedge clk);
    #1 reset = 0; req_valid = 0;
    @(negedge clk);
    chk("reset_bus_valid", 32'(bus_valid), 0);
    chk("reset_B_bus",     32'(B_bus),     0);
    chk("reset_err_count", 32'(err_count), 0);
    chk("reset_req_ready", 32'(req_ready), 1);

    // Narrow and wide selection
    src[0] = 24'hABCD12; src[3] = 24'h123456;
    bus_ready = 1; req_valid = 1; b_control = 4'd1;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    chk("narrow_mdr", 32'(B_bus), 32'h000012);
    chk("narrow_vld", 32'(bus_valid), 1);
    req_valid = 1; b_control = 4'd4;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    chk("wide_r1", 32'(B_bus), 32'h123456);
    @(posedge clk); #1;

    // Back-pressure: R1 held while code5 waits, source changes ignored
    src[4] = 24'h555555;
    bus_ready = 0; req_valid = 1; b_control = 4'd4;
    @(posedge clk); #1 b_control = 4'd5;
    for (int c = 0; c < 3; c++) begin
      src[3] = DW'($urandom);
      @(negedge clk);
      chk("stall_hold_r1", 32'(B_bus), 32'h123456);
      chk("stall_ready",   32'(req_ready), 0);
    end
    bus_ready = 1;
    @(posedge clk); @(negedge clk);
    chk("stall_release_r2", 32'(B_bus), 32'h555555);

    // Streaming codes 4..8 with no bubble
    lit[4] = 24'h111111; lit[5] = 24'h222222; lit[6] = 24'h333333;
    lit[7] = 24'h444444; lit[8] = 24'hFEDCBA;
    for (int k = 4; k <= 8; k++) src[k-1] = lit[k];
    for (int k = 4; k <= 8; k++) begin
      b_control = 4'(k);
      @(posedge clk); @(negedge clk);
      chk("stream_data", 32'(B_bus), 32'(lit[k]));
      chk("stream_vld",  32'(bus_valid), 1);
    end
    req_valid = 0;
    @(posedge clk); #1;

    // Invalid code, then saturation of the error counter
    req_valid = 1; b_control = 4'd9;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    chk("inv_B_bus",   32'(B_bus), 0);
    chk("inv_vld",     32'(bus_valid), 1);
    chk("inv_sel_err", 32'(sel_err), 1);
    chk("inv_count1",  32'(err_count), 1);
    req_valid = 1;
    for (int n = 0; n < 300; n++) begin
      b_control = 4'($urandom_range(9, 15));
      @(posedge clk); #1;
    end
    req_valid = 0;
    @(negedge clk);
    chk("inv_count_sat", 32'(err_count), 32'hFF);
    req_valid = 1; b_control = 4'd6;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    chk("sat_held",    32'(err_count), 32'hFF);
    chk("sticky_held", 32'(sel_err), 1);

    // Reset during a stall
    bus_ready = 0; req_valid = 1; b_control = 4'd2;
    @(posedge clk); #1 req_valid = 0; reset = 1;
    @(negedge clk);
    chk("pre_reset_vld", 32'(bus_valid), 1);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("stall_reset_vld",   32'(bus_valid), 0);
    chk("stall_reset_err",   32'(sel_err), 0);
    chk("stall_reset_count", 32'(err_count), 0);
    chk("stall_reset_bus",   32'(B_bus), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 199) == 0);
      req_valid = $urandom_range(0, 3) != 0;
      bus_ready = $urandom_range(0, 2) != 0;
      b_control = 4'($urandom_range(0, 15));
      for (int i = 0; i < NS; i++) src[i] = DW'($urandom);
    end
    reset = 0; req_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
